// File: rtl/adc_seq_pkg.sv
// Shared types and default constants for the SAR ADC conversion sequencer.
// ADC_SEQ_AVG_EN adds the ACC state used by the averaging build.
package adc_seq_pkg;

  localparam int unsigned DefDw          = 10;
  localparam int unsigned DefIw          = 16;
  localparam int unsigned DefStartCycles = 3;
  localparam int unsigned DefWakeCycles  = 16;
  localparam int unsigned DefTimeout     = 64;
  localparam int unsigned DefMaxAvgLog2  = 4;
  localparam int unsigned DefAccW        = DefDw + DefMaxAvgLog2;

  typedef enum logic [2:0] {
    StOff,
    StWake,
    StIdle,
    StStart,
    StWaitLo,
    StWaitHi
`ifdef ADC_SEQ_AVG_EN
    ,
    StAcc
`endif
  } state_e;

  function automatic logic [2:0] clamp_log2(input logic [2:0] v, input int unsigned lim);
    return (32'(v) > lim) ? 3'(lim) : v;
  endfunction

endpackage

// File: rtl/adc_seq_eoc_sync.sv
// Two-flop synchroniser for the ADC macro EOC line with a rising-edge pulse.
// Flops reset to 1 so an idle-high EOC does not look like an edge after reset.
module adc_seq_eoc_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic eoc_i,
  output logic eoc_o,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], eoc_i};
    end
  end

  // sync_q[2] only remembers the previous synchronised level for edge detection.
  assign eoc_o  = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adc_seq_ctrl.sv
// Conversion sequencer for a SAR ADC macro: wake, START pulse, EOC tracking, result handshake.
// Define ADC_SEQ_AVG_EN to average 2^avg_log2 back-to-back conversions per launch.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int unsigned Dw          = DefDw,
  parameter int unsigned Iw          = DefIw,
  parameter int unsigned StartCycles = DefStartCycles,
  parameter int unsigned WakeCycles  = DefWakeCycles,
  parameter int unsigned Timeout     = DefTimeout,
  parameter int unsigned MaxAvgLog2  = DefMaxAvgLog2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          trig_i,
  input  logic          cont_i,
  input  logic [Iw-1:0] interval_i,
  input  logic [2:0]    avg_log2_i,
  input  logic          err_clr_i,
  output logic          adc_en_o,
  output logic          adc_start_o,
  input  logic          adc_eoc_i,
  input  logic [Dw-1:0] adc_d_i,
  output logic [Dw-1:0] result_o,
  output logic          result_valid_o,
  input  logic          result_ready_i,
  output logic          busy_o,
  output logic          timeout_err_o,
  output logic          overrun_o
);

  localparam int unsigned CntMax = (Timeout > WakeCycles) ?
                                   ((Timeout > StartCycles) ? Timeout : StartCycles) :
                                   ((WakeCycles > StartCycles) ? WakeCycles : StartCycles);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [Iw-1:0]   ivl_q, ivl_d;
  logic            done_q, done_d;
  logic [Dw-1:0]   sample_q, sample_d;
  logic [Dw-1:0]   result_q, result_d;
  logic            valid_q, valid_d;
  logic            tmo_err_q, tmo_err_d;
  logic            ovr_q, ovr_d;
  logic            tmo_hit, ovr_set;
  logic            eoc_sync, eoc_rise;

`ifdef ADC_SEQ_AVG_EN
  localparam int unsigned AccW = Dw + MaxAvgLog2;
  localparam int unsigned SmpW = MaxAvgLog2 + 1;

  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic [SmpW-1:0] smp_cnt_q, smp_cnt_d, last_smp;
  logic [2:0]      avg_q, avg_d;

  assign acc_sum  = acc_q + AccW'(adc_d_i);
  assign last_smp = (SmpW'(1) << avg_q) - SmpW'(1);
`else
  logic unused_avg;
  assign unused_avg = ^avg_log2_i;
`endif

  adc_seq_eoc_sync u_eoc_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .eoc_i  (adc_eoc_i),
    .eoc_o  (eoc_sync),
    .rise_o (eoc_rise)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    pending_d = pending_q | (trig_i & enable_i);
    ivl_d     = (ivl_q != '0) ? ivl_q - 1'b1 : '0;
    done_d    = 1'b0;
    sample_d  = sample_q;
    tmo_hit   = 1'b0;
`ifdef ADC_SEQ_AVG_EN
    acc_d     = acc_q;
    smp_cnt_d = smp_cnt_q;
    avg_d     = avg_q;
`endif
    unique case (state_q)
      StOff: begin
        if (enable_i) state_d = StWake;
      end
      StWake: begin
        if (cnt_q == CntW'(WakeCycles - 1)) state_d = StIdle;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      StIdle: begin
        if (pending_q || (cont_i && ivl_q == '0)) begin
          state_d   = StStart;
          pending_d = trig_i & enable_i;
          // Reload one short so consecutive launches land exactly interval cycles apart.
          ivl_d     = (interval_i == '0) ? '0 : interval_i - 1'b1;
`ifdef ADC_SEQ_AVG_EN
          avg_d     = clamp_log2(avg_log2_i, MaxAvgLog2);
`endif
        end
      end
      StStart: begin
        if (cnt_q == CntW'(StartCycles - 1)) state_d = StWaitLo;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      StWaitLo, StWaitHi: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Timeout - 1)) begin
          tmo_hit   = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
`ifdef ADC_SEQ_AVG_EN
          acc_d     = '0;
          smp_cnt_d = '0;
`endif
        end else if (state_q == StWaitLo) begin
          if (!eoc_sync) state_d = StWaitHi;
        end else if (eoc_rise) begin
          cnt_d = '0;
`ifdef ADC_SEQ_AVG_EN
          if (smp_cnt_q == last_smp) begin
            sample_d  = Dw'(acc_sum >> avg_q);
            done_d    = 1'b1;
            acc_d     = '0;
            smp_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            acc_d     = acc_sum;
            smp_cnt_d = smp_cnt_q + 1'b1;
            state_d   = StAcc;
          end
`else
          sample_d = adc_d_i;
          done_d   = 1'b1;
          state_d  = StIdle;
`endif
        end
      end
`ifdef ADC_SEQ_AVG_EN
      StAcc: state_d = StStart;
`endif
      default: state_d = StOff;
    endcase

    if (!enable_i) begin
      state_d   = StOff;
      cnt_d     = '0;
      pending_d = 1'b0;
      ivl_d     = '0;
      done_d    = 1'b0;
`ifdef ADC_SEQ_AVG_EN
      acc_d     = '0;
      smp_cnt_d = '0;
`endif
    end
  end

  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    ovr_set  = 1'b0;
    if (valid_q && result_ready_i) valid_d = 1'b0;
    if (done_q) begin
      // A result landing on an accepted cycle simply replaces the old one.
      if (valid_q && !result_ready_i) begin
        ovr_set = 1'b1;
      end else begin
        result_d = sample_q;
        valid_d  = 1'b1;
      end
    end
    if (!enable_i) begin
      valid_d = 1'b0;
      ovr_set = 1'b0;
    end
    tmo_err_d = err_clr_i ? 1'b0 : (tmo_err_q | tmo_hit);
    ovr_d     = err_clr_i ? 1'b0 : (ovr_q | ovr_set);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ivl_q     <= '0;
      done_q    <= 1'b0;
      sample_q  <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      acc_q     <= '0;
      smp_cnt_q <= '0;
      avg_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ivl_q     <= ivl_d;
      done_q    <= done_d;
      sample_q  <= sample_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      tmo_err_q <= tmo_err_d;
      ovr_q     <= ovr_d;
`ifdef ADC_SEQ_AVG_EN
      acc_q     <= acc_d;
      smp_cnt_q <= smp_cnt_d;
      avg_q     <= avg_d;
`endif
    end
  end

  assign adc_en_o       = (state_q != StOff);
  assign adc_start_o    = (state_q == StStart);
  assign busy_o         = !(state_q inside {StOff, StWake, StIdle});
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign timeout_err_o  = tmo_err_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: behavioural SAR macro, scoreboard of converted codes, directed
// scenarios plus randomised single shots. Averaging checks only apply with ADC_SEQ_AVG_EN.
module tb_adc_seq_ctrl;

  localparam int unsigned ConvCycles = 12;

  logic       clk = 1'b0;
  logic       rst_n, enable, trig, cont, err_clr, result_ready;
  logic [15:0] interval;
  logic [2:0]  avg_log2;
  logic       adc_en, adc_start, busy, timeout_err, overrun, result_valid;
  logic       adc_eoc = 1'b1;
  logic [9:0] adc_d = '0;
  logic [9:0] result;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          res_cnt  = 0;
  int          eff_log2 = 0;
  int          conv_left = 0;
  bit          sb_on    = 1'b0;
  bit          force_hi = 1'b0;
  logic        start_prev = 1'b0;
  logic [9:0]  force_codes[$];
  int unsigned conv_q[$];
  int          launch_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_seq_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .trig_i         (trig),
    .cont_i         (cont),
    .interval_i     (interval),
    .avg_log2_i     (avg_log2),
    .err_clr_i      (err_clr),
    .adc_en_o       (adc_en),
    .adc_start_o    (adc_start),
    .adc_eoc_i      (adc_eoc),
    .adc_d_i        (adc_d),
    .result_o       (result),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .busy_o         (busy),
    .timeout_err_o  (timeout_err),
    .overrun_o      (overrun)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SAR macro: START pulls EOC low, conversion ends ConvCycles after START drops.
  always @(negedge clk) begin
    if (!rst_n || !adc_en) begin
      adc_eoc   = 1'b1;
      conv_left = 0;
    end else if (adc_start) begin
      adc_eoc   = 1'b0;
      conv_left = ConvCycles;
    end else if (conv_left > 0) begin
      conv_left--;
      if (conv_left == 0) begin
        adc_d   = (force_codes.size() > 0) ? force_codes.pop_front() : 10'($urandom_range(1023, 0));
        adc_eoc = 1'b1;
        conv_q.push_back(adc_d);
      end
    end
    if (force_hi) adc_eoc = 1'b1;
  end

  // Launch recorder and result scoreboard (each accepted result = mean of its conversions).
  always @(negedge clk) begin
    if (rst_n) begin
      if (adc_start && !start_prev) launch_t.push_back(cyc);
      start_prev = adc_start;
      if (sb_on && result_valid && result_ready) begin
        int unsigned n;
        int unsigned sum;
        n = 1 << eff_log2;
        if (conv_q.size() < n) begin
          check_eq("sb_avail", conv_q.size(), n);
        end else begin
          sum = 0;
          for (int i = 0; i < int'(n); i++) sum += conv_q.pop_front();
          check_eq("result", result, sum >> eff_log2);
        end
        res_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int h;
    int res_base;
    int unsigned first_code;
    bit seen;

    rst_n = 1'b0; enable = 1'b0; trig = 1'b0; cont = 1'b0; interval = '0;
    avg_log2 = '0; err_clr = 1'b0; result_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_adc_en", adc_en, 0);
    check_eq("rst_start", adc_start, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    step();

    // Single shot at mid-scale input: trig during wake is held until IDLE.
    force_codes.push_back(10'd512);
    sb_on = 1'b1;
    enable = 1'b1; trig = 1'b1;
    step();
    trig = 1'b0;
    check_eq("en_rise", adc_en, 1);
    k = 0;
    while (!adc_start && k < 100) begin step(); k++; end
    check_eq("wake_to_start", k, 17);
    h = 0;
    while (adc_start && h < 10) begin h++; step(); end
    check_eq("start_len", h, 3);
    k = 0;
    while (!result_valid && k < 100) begin step(); k++; end
    check_eq("valid_1", result_valid, 1);
    check_eq("result_mid", result, 512);
    repeat (5) step();
    check_eq("valid_held", result_valid, 1);
    result_ready = 1'b1;
    step();
    check_eq("valid_drop", result_valid, 0);

    // Periodic mode, interval 40, consumer always ready.
    launch_t.delete();
    res_base = res_cnt;
    interval = 16'd40; cont = 1'b1;
    k = 0;
    while (launch_t.size() < 5 && k < 600) begin step(); k++; end
    cont = 1'b0;
    check_eq("launch_count", launch_t.size() >= 5, 1);
    for (int i = 1; i < 5 && i < launch_t.size(); i++)
      check_eq("launch_gap", launch_t[i] - launch_t[i-1], 40);
    repeat (80) step();
    check_eq("sb_drained", conv_q.size(), 0);
    check_eq("results_vs_launch", res_cnt - res_base, launch_t.size());
    check_eq("no_overrun", overrun, 0);

    // Back-to-back, consumer stalled: first result held, second raises overrun.
    sb_on = 1'b0;
    conv_q.delete();
    result_ready = 1'b0; interval = '0; cont = 1'b1;
    k = 0;
    while (!result_valid && k < 100) begin step(); k++; end
    first_code = (conv_q.size() > 0) ? conv_q[0] : 32'hffff;
    check_eq("ovr_first_valid", result_valid, 1);
    check_eq("ovr_first_result", result, first_code);
    check_eq("ovr_not_yet", overrun, 0);
    k = 0;
    while (!overrun && k < 100) begin step(); k++; end
    check_eq("ovr_set", overrun, 1);
    check_eq("ovr_kept_result", result, first_code);
    check_eq("ovr_kept_valid", result_valid, 1);
    cont = 1'b0;
    repeat (60) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("ovr_clear", overrun, 0);
    check_eq("ovr_result_still", result, first_code);
    result_ready = 1'b1;
    step();
    check_eq("ovr_drain", result_valid, 0);

    // EOC stuck high: timeout after 64 wait cycles, back to IDLE with no result.
    force_hi = 1'b1;
    trig = 1'b1;
    step();
    trig = 1'b0;
    k = 0;
    while (!adc_start && k < 50) begin step(); k++; end
    h = 0;
    while (adc_start && h < 10) begin step(); h++; end
    k = 0;
    while (!timeout_err && k < 200) begin step(); k++; end
    check_eq("tmo_cycles", k, 64);
    check_eq("tmo_idle", busy, 0);
    check_eq("tmo_no_valid", result_valid, 0);
    repeat (10) step();
    check_eq("tmo_sticky", timeout_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("tmo_clear", timeout_err, 0);
    force_hi = 1'b0;
    repeat (20) step();

    // Disable mid-conversion, then re-enable with a pending trig.
    trig = 1'b1;
    step();
    trig = 1'b0;
    k = 0;
    while (!adc_start && k < 50) begin step(); k++; end
    h = 0;
    while (adc_start && h < 10) begin step(); h++; end
    repeat (5) step();
    enable = 1'b0;
    step();
    check_eq("abort_en", adc_en, 0);
    check_eq("abort_start", adc_start, 0);
    check_eq("abort_busy", busy, 0);
    seen = 1'b0;
    repeat (30) begin step(); if (result_valid) seen = 1'b1; end
    check_eq("abort_no_result", seen, 0);
    conv_q.delete();
    sb_on = 1'b1;
    res_base = res_cnt;
    enable = 1'b1; trig = 1'b1;
    step();
    trig = 1'b0;
    k = 0;
    while (!adc_start && k < 100) begin step(); k++; end
    check_eq("rewake_to_start", k, 17);
    k = 0;
    while (res_cnt == res_base && k < 200) begin step(); k++; end
    check_eq("abort_recover", res_cnt - res_base, 1);

    // Randomised single shots with random avg_log2.
    for (int it = 0; it < 6; it++) begin
      avg_log2 = 3'($urandom_range(7, 0));
`ifdef ADC_SEQ_AVG_EN
      eff_log2 = (avg_log2 > 4) ? 4 : int'(avg_log2);
`else
      eff_log2 = 0;
`endif
      res_base = res_cnt;
      trig = 1'b1;
      step();
      trig = 1'b0;
      k = 0;
      while (res_cnt == res_base && k < 800) begin step(); k++; end
      check_eq("shot_done", res_cnt - res_base, 1);
      repeat (3) step();
    end

`ifdef ADC_SEQ_AVG_EN
    // Four conversions 100..103 average to 101.
    avg_log2 = 3'd2; eff_log2 = 2;
    force_codes.push_back(10'd100);
    force_codes.push_back(10'd101);
    force_codes.push_back(10'd102);
    force_codes.push_back(10'd103);
    launch_t.delete();
    result_ready = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    k = 0;
    while (!result_valid && k < 400) begin step(); k++; end
    check_eq("avg_result", result, 101);
    check_eq("avg_starts", launch_t.size(), 4);
    result_ready = 1'b1;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
